// File: rtl/alu_piso_tx_if.sv
// alu_piso_tx_if: load handshake plus serial output bundle for alu_piso_tx.
// Members: load_data/load_valid (producer -> tx), load_ready, sout, sout_valid,
// busy, done, bit_cnt (tx -> consumer/producer). master = producer side, slave = tx.
interface alu_piso_tx_if #(parameter int WIDTH = 8);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;
    logic [CW-1:0]    bit_cnt;
    modport master (output load_data, load_valid,
                    input  load_ready, sout, sout_valid, busy, done, bit_cnt);
    modport slave  (input  load_data, load_valid,
                    output load_ready, sout, sout_valid, busy, done, bit_cnt);
endinterface

// File: rtl/alu_piso_tx.sv
// alu_piso_tx: parallel-in/serial-out word transmitter with valid/ready load and done pulse.
// Ports: clk (rising edge), reset (async, active-low), bus (alu_piso_tx_if.slave:
// load_data/load_valid/load_ready handshake, sout/sout_valid serial stream,
// busy, done, bit_cnt). Optional trailing even-parity bit: define ALU_PISO_PARITY_EN.
module alu_piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic          clk,
    input logic          reset,
    alu_piso_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef ALU_PISO_PARITY_EN
        PAR,
`endif
        DONE
    } state_t;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             w_head;
    logic             w_last;
    assign w_head = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];
    assign w_last = r_cnt == CW'(WIDTH - 1);
`ifdef ALU_PISO_PARITY_EN
    // parity is taken from the captured word, since the register zero-fills while shifting
    logic r_par;
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_par <= 1'b0;
        else if (r_state == IDLE && bus.load_valid)
            r_par <= ^bus.load_data;
    assign bus.sout_valid = r_state == SHIFT || r_state == PAR;
    assign bus.sout       = r_state == SHIFT ? w_head : r_state == PAR && r_par;
`else
    assign bus.sout_valid = r_state == SHIFT;
    assign bus.sout       = r_state == SHIFT && w_head;
`endif
    assign bus.load_ready = r_state == IDLE;
    assign bus.busy       = r_state != IDLE;
    assign bus.done       = r_state == DONE;
    assign bus.bit_cnt    = r_cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE:
                if (bus.load_valid) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = bus.load_data;
                    w_cnt_nxt   = '0;
                end
            SHIFT: begin
                w_shift_nxt = LSB_FIRST ? r_shift >> 1 : r_shift << 1;
                w_cnt_nxt   = r_cnt + 1'b1;
`ifdef ALU_PISO_PARITY_EN
                if (w_last) w_state_nxt = PAR;
`else
                if (w_last) w_state_nxt = DONE;
`endif
            end
`ifdef ALU_PISO_PARITY_EN
            PAR: w_state_nxt = DONE;
`endif
            DONE: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_piso_tx.sv
// tb_alu_piso_tx: randomized self-checking bench for alu_piso_tx (LSB-first and MSB-first instances).
module tb_alu_piso_tx;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
`ifdef ALU_PISO_PARITY_EN
    localparam int NP = 1;
`else
    localparam int NP = 0;
`endif
    localparam int SPAN = W + NP + 2;
    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic [W-1:0] ld_data  = '0;
    logic         ld_valid = 1'b0;
    int           checks   = 0;
    int           failures = 0;
    alu_piso_tx_if #(.WIDTH(W)) if_l ();
    alu_piso_tx_if #(.WIDTH(W)) if_m ();
    assign if_l.load_data  = ld_data;
    assign if_l.load_valid = ld_valid;
    assign if_m.load_data  = ld_data;
    assign if_m.load_valid = ld_valid;
    alu_piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .reset(reset), .bus(if_l));
    alu_piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .reset(reset), .bus(if_m));
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // observed {sout, sout_valid, busy, load_ready, done, bit_cnt}
    function automatic logic [4+CW:0] st(input bit m);
        return m ? {if_m.sout, if_m.sout_valid, if_m.busy, if_m.load_ready, if_m.done, if_m.bit_cnt}
                 : {if_l.sout, if_l.sout_valid, if_l.busy, if_l.load_ready, if_l.done, if_l.bit_cnt};
    endfunction

    // i-th bit on the wire for a word: payload order from the bit-order rule, then parity
    function automatic logic ref_bit(input logic [W-1:0] w, input int i, input bit m);
        if (i >= W) return ^w;
        return m ? w[W-1-i] : w[i];
    endfunction

    // expected status k cycles after the accepting edge (k >= SPAN means back in idle)
    function automatic logic [4+CW:0] exp_st(input logic [W-1:0] w, input int k, input bit m);
        if (k >= 1 && k <= W) return {ref_bit(w, k - 1, m), 4'b1100, CW'(k - 1)};
        if (NP == 1 && k == W + 1) return {ref_bit(w, W, m), 4'b1100, CW'(W)};
        if (k == W + 1 + NP) return {5'b00101, CW'(W)};
        return {5'b00010, CW'(0)};
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        tick;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (st(m) !== exp_st('0, 0, m))
                $display("FAIL reset_state dut=%0d got=%b exp=%b", m, st(m), exp_st('0, 0, m));
            if (st(m) !== exp_st('0, 0, m)) failures++;
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_words;
        logic [W-1:0] fixed [7] = '{8'hA5, 8'h01, 8'h07, 8'h3C, 8'hFF, 8'h00, 8'h80};
        logic [W-1:0] w;
        for (int n = 0; n < 19; n++) begin
            w = n < 7 ? fixed[n] : W'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                ld_valid = 1'b0;
                ld_data  = W'($urandom);
                tick;
                for (int m = 0; m < 2; m++) begin
                    checks++;
                    if (st(m) !== exp_st(w, 0, m)) begin
                        failures++;
                        $display("FAIL idle_gap dut=%0d got=%b exp=%b", m, st(m), exp_st(w, 0, m));
                    end
                end
            end
            ld_data  = w;
            ld_valid = 1'b1;
            tick;
            ld_valid = 1'b0;
            ld_data  = W'($urandom);
            for (int k = 1; k <= SPAN; k++) begin
                for (int m = 0; m < 2; m++) begin
                    checks++;
                    if (st(m) !== exp_st(w, k, m)) begin
                        failures++;
                        $display("FAIL word w=%h k=%0d dut=%0d got=%b exp=%b", w, k, m, st(m), exp_st(w, k, m));
                    end
                end
                if (k < SPAN) tick;
            end
        end
    endtask

    task automatic test_busy_ignore;
        ld_data  = 8'h3C;
        ld_valid = 1'b1;
        tick;
        ld_data  = 8'hFF;
        for (int k = 1; k <= SPAN; k++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (st(m) !== exp_st(8'h3C, k, m)) begin
                    failures++;
                    $display("FAIL busy_ignore k=%0d dut=%0d got=%b exp=%b", k, m, st(m), exp_st(8'h3C, k, m));
                end
            end
            tick;
        end
        ld_valid = 1'b0;
        for (int k = 1; k <= SPAN; k++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (st(m) !== exp_st(8'hFF, k, m)) begin
                    failures++;
                    $display("FAIL held_word k=%0d dut=%0d got=%b exp=%b", k, m, st(m), exp_st(8'hFF, k, m));
                end
            end
            if (k < SPAN) tick;
        end
    endtask

    task automatic test_reset_mid;
        ld_data  = 8'hFF;
        ld_valid = 1'b1;
        tick;
        ld_valid = 1'b0;
        repeat (4) tick;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (st(m) !== exp_st(8'hFF, 5, m)) begin
                failures++;
                $display("FAIL pre_abort dut=%0d got=%b exp=%b", m, st(m), exp_st(8'hFF, 5, m));
            end
        end
        #2 reset = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (st(m) !== exp_st('0, 0, m)) begin
                failures++;
                $display("FAIL async_abort dut=%0d got=%b exp=%b", m, st(m), exp_st('0, 0, m));
            end
        end
        tick;
        reset = 1'b1;
        for (int k = 0; k < SPAN + 1; k++) begin
            tick;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (st(m) !== exp_st('0, 0, m)) begin
                    failures++;
                    $display("FAIL post_abort k=%0d dut=%0d got=%b exp=%b", k, m, st(m), exp_st('0, 0, m));
                end
            end
        end
        ld_data  = 8'h81;
        ld_valid = 1'b1;
        tick;
        ld_valid = 1'b0;
        for (int k = 1; k <= SPAN; k++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (st(m) !== exp_st(8'h81, k, m)) begin
                    failures++;
                    $display("FAIL after_abort k=%0d dut=%0d got=%b exp=%b", k, m, st(m), exp_st(8'h81, k, m));
                end
            end
            if (k < SPAN) tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] obs [2];
        logic [63:0] exp_bits [2];
        int          dones [2];
        int          first [2];
        int          second [2];
        int          acc;
        obs    = '{64'd0, 64'd0};
        dones  = '{0, 0};
        first  = '{-1, -1};
        second = '{-1, -1};
        for (int m = 0; m < 2; m++) begin
            exp_bits[m] = '0;
            for (int i = 0; i < W + NP; i++) exp_bits[m] = {exp_bits[m][62:0], ref_bit(8'h55, i, m)};
            for (int i = 0; i < W + NP; i++) exp_bits[m] = {exp_bits[m][62:0], ref_bit(8'hAA, i, m)};
        end
        ld_data  = 8'h55;
        ld_valid = 1'b1;
        tick;
        ld_data  = 8'hAA;
        acc      = 1;
        for (int n = 1; n <= 2 * SPAN + 2; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (st(m)[3+CW]) obs[m] = {obs[m][62:0], st(m)[4+CW]};
                if (st(m)[CW]) dones[m]++;
                if (st(m)[3+CW] && st(m)[CW-1:0] == '0) begin
                    if (first[m] < 0) first[m] = n;
                    else if (second[m] < 0) second[m] = n;
                end
            end
            if (if_l.load_ready && ld_valid) acc++;
            tick;
            if (acc >= 2) ld_valid = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== exp_bits[m]) begin
                failures++;
                $display("FAIL b2b_stream dut=%0d got=%h exp=%h", m, obs[m], exp_bits[m]);
            end
            checks++;
            if (dones[m] !== 2) begin
                failures++;
                $display("FAIL b2b_done_count dut=%0d got=%0d exp=2", m, dones[m]);
            end
            checks++;
            if (second[m] - first[m] !== SPAN) begin
                failures++;
                $display("FAIL b2b_spacing dut=%0d got=%0d exp=%0d", m, second[m] - first[m], SPAN);
            end
        end
        checks++;
        if (acc !== 2) begin
            failures++;
            $display("FAIL b2b_accepts got=%0d exp=2", acc);
        end
    endtask

    initial begin
        test_reset;
        test_words;
        test_busy_ignore;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_piso_tx.md
Name: alu_piso_tx

Overview:
- Parallel-in / serial-out operand transmitter for the 8-bit ALU datapath. It is the sending end of the serial bit stream that the team's flip-flop chains capture.
- Accepts one WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock, with a qualifier strobe.
- Pulses a completion flag when the word has been sent.
- Sits between the ALU result register and any serial consumer: shift-register receiver, bit-serial adder, or debug port.

Parameters:
- WIDTH, 8, word width in bits; legal values are 2 to 32.
- LSB_FIRST, 1, bit order: 1 sends bit 0 first, 0 sends bit WIDTH-1 first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- load_data  input  WIDTH  word to transmit; sampled only on handshake.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  block can accept a word; equals (state == IDLE).
- sout  output  1  serial data bit.
- sout_valid  output  1  sout holds a valid payload or parity bit this cycle.
- busy  output  1  high in every state other than IDLE.
- done  output  1  single-cycle pulse after the last bit.
- bit_cnt  output  $clog2(WIDTH+1)  number of bits already driven in the current word.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit_cnt=0.
  - sout=0, sout_valid=0, busy=0, done=0, load_ready=1.
  - Reset in the middle of a word aborts it immediately. No done pulse is produced and no partial word is retained.
- States: IDLE, SHIFT, PAR (only when PARITY_EN is defined), DONE.
- IDLE:
  - load_ready=1, sout=0, sout_valid=0.
  - On an edge with load_valid=1: capture load_data into the shift register, set bit_cnt=0, go to SHIFT.
  - With load_valid=0 the block stays in IDLE.
- SHIFT:
  - sout is the shift-register bit at position 0 when LSB_FIRST=1, or position WIDTH-1 when LSB_FIRST=0. sout_valid=1.
  - Every edge shifts the register by one toward the output end, zero-filling, and increments bit_cnt.
  - On the edge where bit_cnt goes from WIDTH-1 to WIDTH: go to PAR if PARITY_EN is defined, otherwise go to DONE.
- PAR: sout = parity bit (see Optional Feature), sout_valid=1, bit_cnt holds at WIDTH. The next edge goes to DONE.
- DONE: done=1, sout_valid=0, sout=0, load_ready=0. The next edge goes to IDLE and clears bit_cnt.
- Latency:
  - Handshake edge to first bit on sout: 1 cycle.
  - Word occupies WIDTH cycles, plus 1 with parity.
  - done appears in the cycle immediately after the last bit.
  - Minimum spacing between accepted words is WIDTH+2 cycles (WIDTH+3 with parity).
- Handshake rules:
  - load_valid while busy is ignored; the word is not queued.
  - load_data may change freely except on the accepting edge.
  - The producer must hold load_valid until it sees load_ready.
- Outputs are registered-state decodes only: no combinational path from load_valid to sout or sout_valid. load_ready depends only on state.

Optional Feature:
- Macro: ALU_PISO_PARITY_EN.
- Defined:
  - PAR state is present and sends one extra bit after the payload.
  - The bit is even parity: XOR of all WIDTH bits of the captured word. It is latched at capture time, not recomputed from the shifting register.
  - sout_valid stays high for WIDTH+1 consecutive cycles.
- Undefined:
  - PAR state and parity logic are absent.
  - SHIFT goes directly to DONE.
  - sout_valid is high for exactly WIDTH cycles.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, no parity. Load 0xA5 at cycle 0.
   - Cycles 1-8: sout = 1,0,1,0,0,1,0,1 with sout_valid=1 and bit_cnt = 0..7.
   - Cycle 9: done=1. Cycle 10: load_ready=1.
2. LSB_FIRST=0. Load 0xA5.
   - sout = 1,0,1,0,0,1,0,1 (MSB first); done at cycle 9.
   - Load 0x01: sout = 0,0,0,0,0,0,0,1.
3. ALU_PISO_PARITY_EN defined, LSB_FIRST=1.
   - Load 0xA5 (four ones): bit 9 = 0, done at cycle 10.
   - Load 0x07 (three ones): parity bit = 1.
4. Load 0x3C, then hold load_valid=1 with load_data=0xFF through cycles 1-9.
   - 0x3C is sent intact; 0xFF is accepted only on the cycle-10 edge, its first bit appears at cycle 11.
5. Load 0xFF, drive reset=0 asynchronously mid-cycle during bit 4.
   - Immediately: sout=0, sout_valid=0, busy=0, bit_cnt=0, load_ready=1.
   - No done pulse follows.
   - After reset=1, loading 0x81 gives a clean 1,0,0,0,0,0,0,1.
6. Back-to-back: load_valid held high with words 0x55 then 0xAA.
   - Exactly one idle-qualified cycle: sout_valid=0 in DONE plus the accept edge.
   - Both streams are correct; done pulses exactly twice.
